// File: rtl/btc_nonce_scheduler.sv
// Nonce-range scheduler for a one-shot miner core: launches one nonce per start,
// collects winning nonces in a show-ahead hit FIFO and reports per-job status.
module btc_nonce_scheduler #(
  parameter int HIT_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        wb_rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_nonce_first,
  input  logic [31:0] job_nonce_last,
  input  logic        cfg_stop_on_hit,
  input  logic        abort,
  output logic        core_start,
  output logic [31:0] core_nonce_in,
  output logic        core_use_nonce_in,
  output logic        core_oneshot,
  input  logic        core_done,
  input  logic        core_nonce_found,
  input  logic [31:0] core_nonce_out,
  output logic        hit_valid,
  output logic [31:0] hit_nonce,
  input  logic        hit_ready,
  output logic        hit_overflow,
  output logic        busy,
  output logic        job_done,
  output logic [1:0]  job_status,
  output logic [31:0] nonces_tried
);
  localparam int AW = $clog2(HIT_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [TW-1:0] TONE = TW'(1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH} state_e;
  typedef enum logic [1:0] {ST_COMPLETE, ST_HIT_STOP, ST_ABORTED, ST_TIMEOUT} status_e;

  state_e        state_q, state_d;
  status_e       status_q, status_d;
  logic [31:0]   cur_q, cur_d, last_q, last_d, tried_q, tried_d;
  logic          stop_q, stop_d, ovf_q, ovf_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_q [HIT_DEPTH];
  logic          push, pop, full, empty, wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && hit_ready;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cur_d    = cur_q;
    last_d   = last_q;
    stop_d   = stop_q;
    tried_d  = tried_q;
    ovf_d    = ovf_q;
    timer_d  = timer_q;
    push     = 1'b0;
    case (state_q)
      S_IDLE: if (job_valid) begin
        cur_d   = job_nonce_first;
        last_d  = job_nonce_last;
        stop_d  = cfg_stop_on_hit;
        tried_d = '0;
        ovf_d   = 1'b0;
        state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        timer_d = '0;
        if (abort) begin
          status_d = ST_ABORTED;
          state_d  = S_FINISH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TONE;
        if (abort) begin
          status_d = ST_ABORTED;
          state_d  = S_FINISH;
        end else if (core_done) begin
          tried_d = tried_q + 32'd1;
          if (core_nonce_found) begin
            push = 1'b1;
            if (full && !pop) ovf_d = 1'b1;
          end
          if (core_nonce_found && stop_q) begin
            status_d = ST_HIT_STOP;
            state_d  = S_FINISH;
          end else if (cur_q == last_q) begin
            status_d = ST_COMPLETE;
            state_d  = S_FINISH;
          end else begin
            cur_d   = cur_q + 32'd1;
            state_d = S_LAUNCH;
          end
        end else if (timer_q == TLAST) begin
          status_d = ST_TIMEOUT;
          state_d  = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    wr_ptr_d = wr_en ? wr_ptr_q + PONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PONE : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (wb_rst) begin
      state_q  <= S_IDLE;
      status_q <= ST_COMPLETE;
      cur_q    <= '0;
      last_q   <= '0;
      stop_q   <= 1'b0;
      tried_q  <= '0;
      ovf_q    <= 1'b0;
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      stop_q   <= stop_d;
      tried_q  <= tried_d;
      ovf_q    <= ovf_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wb_rst) mem_q[wr_ptr_q[AW-1:0]] <= core_nonce_out;
  end

  assign job_ready         = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign core_start        = (state_q == S_LAUNCH);
  assign job_done          = (state_q == S_FINISH);
  assign core_nonce_in     = cur_q;
  assign core_use_nonce_in = 1'b1;
  assign core_oneshot      = 1'b1;
  assign hit_valid         = !empty;
  assign hit_nonce         = empty ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign hit_overflow      = ovf_q;
  assign job_status        = status_q;
  assign nonces_tried      = tried_q;
endmodule

// File: tb/tb_btc_nonce_scheduler.sv
// Scoreboard bench for btc_nonce_scheduler: stimulus queues expected starts, hits
// and job results; a monitor compares them as the DUT presents them.
module tb_btc_nonce_scheduler;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic wb_rst = 1'b1;
  logic job_valid = 1'b0, job_ready;
  logic [31:0] job_nonce_first = '0, job_nonce_last = '0;
  logic cfg_stop_on_hit = 1'b0, abort;
  logic core_start, core_use_nonce_in, core_oneshot;
  logic [31:0] core_nonce_in;
  logic core_done, core_nonce_found;
  logic [31:0] core_nonce_out;
  logic hit_valid, hit_ready, hit_overflow, busy, job_done;
  logic [31:0] hit_nonce, nonces_tried;
  logic [1:0] job_status;

  btc_nonce_scheduler #(.HIT_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .wb_rst(wb_rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_nonce_first(job_nonce_first), .job_nonce_last(job_nonce_last),
    .cfg_stop_on_hit(cfg_stop_on_hit), .abort(abort), .core_start(core_start),
    .core_nonce_in(core_nonce_in), .core_use_nonce_in(core_use_nonce_in),
    .core_oneshot(core_oneshot), .core_done(core_done),
    .core_nonce_found(core_nonce_found), .core_nonce_out(core_nonce_out),
    .hit_valid(hit_valid), .hit_nonce(hit_nonce), .hit_ready(hit_ready),
    .hit_overflow(hit_overflow), .busy(busy), .job_done(job_done),
    .job_status(job_status), .nonces_tried(nonces_tried)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [1:0] st; logic [31:0] tried; } job_exp_t;
  logic [31:0] exp_nonce_q[$];
  logic [31:0] exp_hit_q[$];
  job_exp_t    exp_job_q[$];
  int start_times[$];
  int done_cyc = 0, done_cnt = 0;

  // core model controls
  int core_delay = 3, cd_cnt = 0;
  logic core_en = 1'b1, hr_base = 1'b1, pop_on_done = 1'b0, abort_on_done = 1'b0;
  logic [31:0] hit_lo = 32'd1, hit_hi = 32'd0, cd_nonce = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endfunction

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!wb_rst) begin
      if (core_start) begin
        start_times.push_back(cyc);
        if (exp_nonce_q.size() == 0) fail_now("unexpected_start", {32'd0, core_nonce_in});
        else check("start_nonce", {32'd0, core_nonce_in}, {32'd0, exp_nonce_q.pop_front()});
      end
      if (job_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_job_q.size() == 0) fail_now("unexpected_job_done", {30'd0, job_status, nonces_tried});
        else check("job_result", {30'd0, job_status, nonces_tried}, {30'd0, exp_job_q.pop_front()});
      end
      if (hit_valid && hit_ready) begin
        if (exp_hit_q.size() == 0) fail_now("unexpected_hit_pop", {32'd0, hit_nonce});
        else check("hit_nonce", {32'd0, hit_nonce}, {32'd0, exp_hit_q.pop_front()});
      end
    end
  end

  // Core model: done core_delay cycles after each start; also drives hit_ready/abort
  initial begin
    core_done = 1'b0; core_nonce_found = 1'b0; core_nonce_out = '0;
    hit_ready = 1'b0; abort = 1'b0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      core_nonce_found = 1'b0;
      if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) begin
          core_done = 1'b1;
          core_nonce_found = (cd_nonce >= hit_lo) && (cd_nonce <= hit_hi);
          core_nonce_out = cd_nonce;
        end
      end
      if (core_start && core_en && !wb_rst) begin
        cd_nonce = core_nonce_in;
        cd_cnt = core_delay;
      end
      hit_ready = hr_base | (core_done & pop_on_done);
      abort = core_done & abort_on_done;
    end
  end

  task automatic start_job(input logic [31:0] f, input logic [31:0] l, input logic s);
    job_valid = 1'b1; job_nonce_first = f; job_nonce_last = l; cfg_stop_on_hit = s;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 2000; n++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    if (n >= 2000) fail_now({name, "_timeout"}, 64'(n));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic exp_range(input logic [31:0] f, input int n);
    logic [31:0] v;
    v = f;
    for (int i = 0; i < n; i++) begin
      exp_nonce_q.push_back(v);
      v = v + 32'd1;
    end
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_job_ready"}, 64'(job_ready), 64'd1);
    check({t, "_busy"}, 64'(busy), 64'd0);
    check({t, "_core_start"}, 64'(core_start), 64'd0);
    check({t, "_core_nonce_in"}, 64'(core_nonce_in), 64'd0);
    check({t, "_use_nonce"}, 64'(core_use_nonce_in), 64'd1);
    check({t, "_oneshot"}, 64'(core_oneshot), 64'd1);
    check({t, "_hit_valid"}, 64'(hit_valid), 64'd0);
    check({t, "_hit_nonce"}, 64'(hit_nonce), 64'd0);
    check({t, "_overflow"}, 64'(hit_overflow), 64'd0);
    check({t, "_job_done"}, 64'(job_done), 64'd0);
    check({t, "_status"}, 64'(job_status), 64'd0);
    check({t, "_tried"}, 64'(nonces_tried), 64'd0);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    wb_rst = 1'b0;
    @(posedge clk); #1;

    // 1: plain range, spacing 4
    start_times.delete();
    exp_range(32'd10, 4);
    exp_job_q.push_back('{2'd0, 32'd4});
    start_job(32'd10, 32'd13, 1'b0);
    wait_idle("t1");
    check("t1_starts", 64'(start_times.size()), 64'd4);
    for (int i = 1; i < start_times.size(); i++)
      check("t1_spacing", 64'(start_times[i] - start_times[i-1]), 64'd4);

    // 2: wrap through 0xFFFFFFFF
    exp_range(32'hFFFF_FFFE, 4);
    exp_job_q.push_back('{2'd0, 32'd4});
    start_job(32'hFFFF_FFFE, 32'd1, 1'b0);
    wait_idle("t2");

    // 3a: stop on hit at 7
    hit_lo = 32'd7; hit_hi = 32'd7;
    exp_range(32'd0, 8);
    exp_job_q.push_back('{2'd1, 32'd8});
    exp_hit_q.push_back(32'd7);
    start_job(32'd0, 32'd99, 1'b1);
    wait_idle("t3a");
    // 3b: same without stop
    core_delay = 1;
    exp_range(32'd0, 100);
    exp_job_q.push_back('{2'd0, 32'd100});
    exp_hit_q.push_back(32'd7);
    start_job(32'd0, 32'd99, 1'b0);
    wait_idle("t3b");
    check("t3b_overflow", 64'(hit_overflow), 64'd0);

    // 4: six hits into a 4-deep FIFO with no pops
    hr_base = 1'b0; hit_lo = 32'd20; hit_hi = 32'd25;
    exp_range(32'd20, 6);
    exp_job_q.push_back('{2'd0, 32'd6});
    start_job(32'd20, 32'd25, 1'b0);
    wait_idle("t4");
    check("t4_overflow", 64'(hit_overflow), 64'd1);
    check("t4_hit_valid", 64'(hit_valid), 64'd1);
    for (int i = 20; i < 24; i++) exp_hit_q.push_back(32'(i));
    hr_base = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t4_drained", 64'(hit_valid), 64'd0);
    check("t4_overflow_sticky", 64'(hit_overflow), 64'd1);

    // 4b: fill, then push and pop in the same cycle while full
    hr_base = 1'b0; hit_lo = 32'd30; hit_hi = 32'd33;
    repeat (2) @(posedge clk);
    #1;
    exp_range(32'd30, 4);
    exp_job_q.push_back('{2'd0, 32'd4});
    start_job(32'd30, 32'd33, 1'b0);
    wait_idle("t4b_fill");
    check("t4b_overflow_cleared", 64'(hit_overflow), 64'd0);
    hit_lo = 32'd40; hit_hi = 32'd40; pop_on_done = 1'b1;
    exp_range(32'd40, 1);
    exp_job_q.push_back('{2'd0, 32'd1});
    exp_hit_q.push_back(32'd30);
    start_job(32'd40, 32'd40, 1'b0);
    wait_idle("t4b_pp");
    check("t4b_no_overflow", 64'(hit_overflow), 64'd0);
    pop_on_done = 1'b0;
    exp_hit_q.push_back(32'd31); exp_hit_q.push_back(32'd32);
    exp_hit_q.push_back(32'd33); exp_hit_q.push_back(32'd40);
    hr_base = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t4b_drained", 64'(hit_valid), 64'd0);

    // 5: abort coincident with a found done; job_valid while busy
    core_delay = 3; hit_lo = 32'd50; hit_hi = 32'd50; abort_on_done = 1'b1;
    exp_range(32'd50, 1);
    exp_job_q.push_back('{2'd2, 32'd0});
    start_job(32'd50, 32'd52, 1'b0);
    job_valid = 1'b1; job_nonce_first = 32'd99; job_nonce_last = 32'd99;
    check("t5_ready_busy", 64'(job_ready), 64'd0);
    @(posedge clk); #1;
    job_valid = 1'b0;
    wait_idle("t5");
    abort_on_done = 1'b0;
    check("t5_no_push", 64'(hit_valid), 64'd0);

    // 6: core never answers
    core_en = 1'b0; hit_lo = 32'd1; hit_hi = 32'd0;
    start_times.delete();
    exp_range(32'd60, 1);
    exp_job_q.push_back('{2'd3, 32'd0});
    start_job(32'd60, 32'd61, 1'b0);
    wait_idle("t6");
    if (start_times.size() > 0) check("t6_timeout_latency", 64'(done_cyc - start_times[0]), 64'(TMO + 1));
    else fail_now("t6_no_start", 64'd0);

    // 7: leave an entry in the FIFO, then reset in the middle of WAIT
    core_en = 1'b1; hr_base = 1'b0; hit_lo = 32'd70; hit_hi = 32'd70;
    exp_range(32'd70, 1);
    exp_job_q.push_back('{2'd0, 32'd1});
    start_job(32'd70, 32'd70, 1'b0);
    wait_idle("t7a");
    core_en = 1'b0;
    exp_range(32'd71, 1);
    start_job(32'd71, 32'd72, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("t7_busy", 64'(busy), 64'd1);
    check("t7_hit_held", 64'(hit_valid), 64'd1);
    d0 = done_cnt;
    wb_rst = 1'b1;
    @(posedge clk); #1;
    wb_rst = 1'b0;
    check_reset_vals("t7");
    repeat (10) @(posedge clk);
    #1;
    check("t7_no_job_done", 64'(done_cnt), 64'(d0));

    check("left_nonces", 64'(exp_nonce_q.size()), 64'd0);
    check("left_hits", 64'(exp_hit_q.size()), 64'd0);
    check("left_jobs", 64'(exp_job_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
